// File: rtl/sdram_pkg.sv
// Shared SDRAM init definitions: command encodings, FSM state type and the
// load-mode-register word encoder.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_LMR  = 4'b0000;

   typedef enum logic [2:0] {
      S_PWRUP,
      S_PRE,
      S_WAIT_RP,
      S_AREF,
      S_WAIT_RFC,
      S_LMR,
      S_WAIT_MRD,
      S_DONE
   } init_state_t;

   function automatic logic [2:0] bl_code(input int bl);
      logic [2:0] code;
      case (bl)
         1:       code = 3'b000;
         2:       code = 3'b001;
         4:       code = 3'b010;
         8:       code = 3'b011;
         default: code = 3'b010;
      endcase
      return code;
   endfunction

   // Low 10 bits of the mode register; callers zero-extend to the address width.
   function automatic logic [9:0] mode_word(input int bl, input int bt,
                                            input int cl, input int wb);
      logic [9:0] w;
      w      = '0;
      w[2:0] = bl_code(bl);
      w[3]   = bt[0];
      w[6:4] = cl[2:0];
      w[9]   = wb[0];
      return w;
   endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable down-counter that saturates at zero; o_zero flags expiry.
module sdram_delay_cnt #(
   parameter int               WIDTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_srst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_srst)
         r_count <= RST_VAL;
      else if (i_load)
         r_count <= i_load_val;
      else if (r_count != '0)
         r_count <= r_count - WIDTH'(1);
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer (PRE, N x AREF, LMR, then done).
// Define SDRAM_INIT_SIM_EN to shorten the power-up wait to 16 cycles.
module sdram_init_seq
   import sdram_pkg::*;
#(
   parameter int ADDR_BITS   = 12,
   parameter int BA_BITS     = 2,
   parameter int T_PWRUP     = 13333,
   parameter int T_RP        = 3,
   parameter int T_RFC       = 9,
   parameter int T_MRD       = 2,
   parameter int N_AREF      = 2,
   parameter int BURST_LEN   = 4,
   parameter int BURST_TYPE  = 0,
   parameter int CAS_LAT     = 3,
   parameter int WRITE_BURST = 0
) (
   input  logic                 sdram_clk,
   input  logic                 rst,
   input  logic                 init_req,
   output logic [3:0]           cmd_reg,
   output logic [ADDR_BITS-1:0] sdram_addr,
   output logic [BA_BITS-1:0]   sdram_ba,
   output logic                 cke,
   output logic                 init_busy,
   output logic                 init_done
);

`ifdef SDRAM_INIT_SIM_EN
   localparam int P_WAIT = 16;
`else
   localparam int P_WAIT = T_PWRUP;
`endif

   localparam int MAX_A   = (P_WAIT > T_RFC) ? P_WAIT : T_RFC;
   localparam int MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Wait states are entered one cycle after the command, hence T_x - 2.
   localparam logic [CNT_W-1:0] LD_RP  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
   localparam logic [CNT_W-1:0] LD_RFC = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
   localparam logic [CNT_W-1:0] LD_MRD = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);

   localparam logic [ADDR_BITS-1:0] ADDR_PALL = ADDR_BITS'(1024);
   localparam logic [ADDR_BITS-1:0] ADDR_MODE =
      ADDR_BITS'(mode_word(BURST_LEN, BURST_TYPE, CAS_LAT, WRITE_BURST));
   localparam logic [3:0] N_AREF_L = 4'(N_AREF);

   if (ADDR_BITS < 11) begin : g_err_addr
      $error("sdram_init_seq: ADDR_BITS must be at least 11");
   end
   if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_err_bl
      $error("sdram_init_seq: BURST_LEN must be 1, 2, 4 or 8");
   end
   if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_err_cl
      $error("sdram_init_seq: CAS_LAT must be 2 or 3");
   end
   if (N_AREF < 1 || N_AREF > 15) begin : g_err_naref
      $error("sdram_init_seq: N_AREF must be 1..15");
   end
   if (T_PWRUP < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1) begin : g_err_tim
      $error("sdram_init_seq: timing parameters must be non-zero");
   end

   init_state_t          r_state, w_state_next;
   logic [3:0]           r_aref_cnt;
   logic [3:0]           r_cmd, w_cmd_next;
   logic [ADDR_BITS-1:0] r_addr;
   logic                 r_cke, r_busy, r_done;
   logic                 w_load, w_zero;
   logic [CNT_W-1:0]     w_load_val;

   sdram_delay_cnt #(
      .WIDTH   (CNT_W),
      .RST_VAL (CNT_W'(P_WAIT))
   ) u_delay (
      .i_clk      (sdram_clk),
      .i_srst     (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_val   = '0;
      case (r_state)
         S_PWRUP:    if (w_zero) w_state_next = S_PRE;
         S_PRE: begin
            if (T_RP == 1) begin
               w_state_next = S_AREF;
            end else begin
               w_state_next = S_WAIT_RP;
               w_load       = 1'b1;
               w_load_val   = LD_RP;
            end
         end
         S_WAIT_RP:  if (w_zero) w_state_next = S_AREF;
         S_AREF: begin
            if (T_RFC == 1) begin
               w_state_next = (r_aref_cnt == N_AREF_L) ? S_LMR : S_AREF;
            end else begin
               w_state_next = S_WAIT_RFC;
               w_load       = 1'b1;
               w_load_val   = LD_RFC;
            end
         end
         S_WAIT_RFC: if (w_zero) w_state_next = (r_aref_cnt == N_AREF_L) ? S_LMR : S_AREF;
         S_LMR: begin
            if (T_MRD == 1) begin
               w_state_next = S_DONE;
            end else begin
               w_state_next = S_WAIT_MRD;
               w_load       = 1'b1;
               w_load_val   = LD_MRD;
            end
         end
         S_WAIT_MRD: if (w_zero) w_state_next = S_DONE;
         S_DONE:     if (init_req) w_state_next = S_PRE;
         default:    w_state_next = S_PWRUP;
      endcase

      case (w_state_next)
         S_PRE:   w_cmd_next = CMD_PRE;
         S_AREF:  w_cmd_next = CMD_AREF;
         S_LMR:   w_cmd_next = CMD_LMR;
         default: w_cmd_next = CMD_NOP;
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge sdram_clk) begin
      if (rst) begin
         r_state    <= S_PWRUP;
         r_aref_cnt <= '0;
         r_cmd      <= CMD_NOP;
         r_addr     <= ADDR_PALL;
         r_cke      <= 1'b0;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_cmd   <= w_cmd_next;
         r_addr  <= (w_state_next == S_LMR) ? ADDR_MODE : ADDR_PALL;
         r_cke   <= 1'b1;
         r_busy  <= (w_state_next != S_DONE);
         r_done  <= (w_state_next == S_DONE);
         if (w_state_next == S_PRE)
            r_aref_cnt <= '0;
         else if (w_state_next == S_AREF)
            r_aref_cnt <= r_aref_cnt + 4'd1;
      end
   end

   assign cmd_reg    = r_cmd;
   assign sdram_addr = r_addr;
   assign sdram_ba   = '0;
   assign cke        = r_cke;
   assign init_busy  = r_busy;
   assign init_done  = r_done;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: default instance and a 4-refresh/BL8/CL2 instance.
module tb_sdram_init_seq;

   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_PRE  = 4'b0010;
   localparam logic [3:0] C_AREF = 4'b0001;
   localparam logic [3:0] C_LMR  = 4'b0000;

`ifdef SDRAM_INIT_SIM_EN
   localparam int P = 16;
`else
   localparam int P = 13333;
`endif

   localparam logic [20:0] RSTV = {C_NOP, 12'h400, 2'b00, 1'b0, 1'b1, 1'b0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst   = 1'b1;
   logic        req_a = 1'b0;
   logic        req_b = 1'b0;
   logic [3:0]  a_cmd, b_cmd;
   logic [11:0] a_addr, b_addr;
   logic [1:0]  a_ba, b_ba;
   logic        a_cke, a_busy, a_done, b_cke, b_busy, b_done;
   logic [20:0] a_vec, b_vec;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   assign a_vec = {a_cmd, a_addr, a_ba, a_cke, a_busy, a_done};
   assign b_vec = {b_cmd, b_addr, b_ba, b_cke, b_busy, b_done};

   sdram_init_seq dut_a (
      .sdram_clk  (clk),
      .rst        (rst),
      .init_req   (req_a),
      .cmd_reg    (a_cmd),
      .sdram_addr (a_addr),
      .sdram_ba   (a_ba),
      .cke        (a_cke),
      .init_busy  (a_busy),
      .init_done  (a_done)
   );

   sdram_init_seq #(
      .N_AREF     (4),
      .T_RFC      (7),
      .BURST_LEN  (8),
      .CAS_LAT    (2),
      .BURST_TYPE (1)
   ) dut_b (
      .sdram_clk  (clk),
      .rst        (rst),
      .init_req   (req_b),
      .cmd_reg    (b_cmd),
      .sdram_addr (b_addr),
      .sdram_ba   (b_ba),
      .cke        (b_cke),
      .init_busy  (b_busy),
      .init_done  (b_done)
   );

   // Expected bus word t cycles after PRE (t < 0: before the sequence starts).
   function automatic logic [20:0] expv(input int t, input int n_aref, input int t_rfc,
                                        input logic [11:0] mode, input bit before_done);
      logic [3:0]  c;
      logic [11:0] ad;
      bit          dn;
      int          lmr;
      c   = C_NOP;
      ad  = 12'h400;
      lmr = 3 + n_aref * t_rfc;
      if (t < 0) begin
         dn = before_done;
      end else begin
         dn = (t >= lmr + 2);
         if (t == 0) c = C_PRE;
         for (int k = 0; k < n_aref; k++)
            if (t == 3 + k * t_rfc) c = C_AREF;
         if (t == lmr) begin
            c  = C_LMR;
            ad = mode;
         end
      end
      return {c, ad, 2'b00, 1'b1, ~dn, dn};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      tests++;
      if (a_vec !== RSTV) begin
         $display("FAIL reset_a got=%h want=%h", a_vec, RSTV);
         fails++;
      end
      tests++;
      if (b_vec !== RSTV) begin
         $display("FAIL reset_b got=%h want=%h", b_vec, RSTV);
         fails++;
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_default_seq();
      logic [20:0] ea, eb;
      bit bad;
      bad = 0;
      rst = 1'b0;
      cyc = -1;
      while (cyc < P + 38 && !bad) begin
         tick();
         ea = expv(cyc - P, 2, 9, 12'h032, 1'b0);
         eb = expv(cyc - P, 4, 7, 12'h02B, 1'b0);
         tests++;
         if (a_vec !== ea) begin
            $display("FAIL powerup_a cyc=%0d got=%h want=%h", cyc, a_vec, ea);
            fails++;
            bad = 1;
         end
         tests++;
         if (b_vec !== eb) begin
            $display("FAIL powerup_b cyc=%0d got=%h want=%h", cyc, b_vec, eb);
            fails++;
            bad = 1;
         end
      end
      $display("[TB] test_default_seq done at cycle %0d", cyc);
   endtask

   task automatic test_reinit();
      logic [20:0] ea, eb;
      bit bad;
      int s;
      bad   = 0;
      s     = cyc + 1;
      req_a = 1'b1;
      req_b = 1'b1;
      for (int i = 0; i < 37 && !bad; i++) begin
         tick();
         req_a = 1'b0;
         req_b = 1'b0;
         ea = expv(cyc - s, 2, 9, 12'h032, 1'b1);
         eb = expv(cyc - s, 4, 7, 12'h02B, 1'b1);
         tests++;
         if (a_vec !== ea) begin
            $display("FAIL reinit_a cyc=%0d got=%h want=%h", cyc, a_vec, ea);
            fails++;
            bad = 1;
         end
         tests++;
         if (b_vec !== eb) begin
            $display("FAIL reinit_b cyc=%0d got=%h want=%h", cyc, b_vec, eb);
            fails++;
            bad = 1;
         end
      end
      $display("[TB] test_reinit done");
   endtask

   task automatic test_req_ignored();
      logic [20:0] ea, eb;
      bit bad;
      bad = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = -1;
      while (cyc < P + 31 && !bad) begin
         req_a = ((cyc >= 10 && cyc < 30) || cyc >= P + 23);
         tick();
         if (cyc >= P + 24)
            ea = expv(cyc - (P + 24), 2, 9, 12'h032, 1'b1);
         else
            ea = expv(cyc - P, 2, 9, 12'h032, 1'b0);
         eb = expv(cyc - P, 4, 7, 12'h02B, 1'b0);
         tests++;
         if (a_vec !== ea) begin
            $display("FAIL req_busy_a cyc=%0d got=%h want=%h", cyc, a_vec, ea);
            fails++;
            bad = 1;
         end
         tests++;
         if (b_vec !== eb) begin
            $display("FAIL req_busy_b cyc=%0d got=%h want=%h", cyc, b_vec, eb);
            fails++;
            bad = 1;
         end
      end
      req_a = 1'b0;
      $display("[TB] test_req_ignored done");
   endtask

   task automatic test_reset_mid();
      logic [20:0] ea, eb;
      bit bad;
      bad = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      cyc = -1;
      while (cyc < 30 && !bad) begin
         tick();
         ea = expv(cyc - P, 2, 9, 12'h032, 1'b0);
         tests++;
         if (a_vec !== ea) begin
            $display("FAIL pre_abort_a cyc=%0d got=%h want=%h", cyc, a_vec, ea);
            fails++;
            bad = 1;
         end
      end
      rst = 1'b1;
      tick();
      tests++;
      if (a_vec !== RSTV) begin
         $display("FAIL abort_a got=%h want=%h", a_vec, RSTV);
         fails++;
      end
      tests++;
      if (b_vec !== RSTV) begin
         $display("FAIL abort_b got=%h want=%h", b_vec, RSTV);
         fails++;
      end
      rst = 1'b0;
      cyc = -1;
      bad = 0;
      while (cyc < P + 24 && !bad) begin
         tick();
         ea = expv(cyc - P, 2, 9, 12'h032, 1'b0);
         eb = expv(cyc - P, 4, 7, 12'h02B, 1'b0);
         tests++;
         if (a_vec !== ea) begin
            $display("FAIL restart_a cyc=%0d got=%h want=%h", cyc, a_vec, ea);
            fails++;
            bad = 1;
         end
         tests++;
         if (b_vec !== eb) begin
            $display("FAIL restart_b cyc=%0d got=%h want=%h", cyc, b_vec, eb);
            fails++;
            bad = 1;
         end
      end
      $display("[TB] test_reset_mid done");
   endtask

   initial begin
      test_reset();
      test_default_seq();
      test_reinit();
      test_req_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
